// File: rtl/eth_tx_sched.sv
// eth_tx_sched: fixed-priority (ARP > ICMP > UDP) GMII TX arbiter with inter-frame gap and hold watchdog.
// Ports: *_tx_start request pulses in; *_tx_done completions in; *_gmii_tx_en/*_gmii_txd per-source GMII in;
// *_tx_go launch pulses out; gmii_tx_en/gmii_txd merged GMII out (1-cycle registered);
// sel owner (0 none, 1 ARP, 2 ICMP, 3 UDP); busy (state != IDLE); timeout_err watchdog release pulse.
module eth_tx_sched #(
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arp_tx_start,
  input  logic       icmp_tx_start,
  input  logic       udp_tx_start,
  input  logic       arp_tx_done,
  input  logic       icmp_tx_done,
  input  logic       udp_tx_done,
  input  logic       arp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic       icmp_gmii_tx_en,
  input  logic [7:0] icmp_gmii_txd,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] udp_gmii_txd,
  output logic       arp_tx_go,
  output logic       icmp_tx_go,
  output logic       udp_tx_go,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout_err
);
  localparam int WD_W  = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_ACTIVE, S_GAP} state_t;
  state_t           r_state, w_next;
  logic [2:0]       r_pend, r_go, w_go, w_start, w_clr;
  logic [1:0]       r_sel, w_sel, w_pick;
  logic [WD_W-1:0]  r_wd;
  logic [GAP_W-1:0] r_gap;
  logic             r_tmo, w_tmo, r_busy, r_tx_en, w_sel_done, w_src_en, w_fwd;
  logic [7:0]       r_txd, w_src_txd;
  assign w_start    = {udp_tx_start, icmp_tx_start, arp_tx_start};
  assign w_pick     = r_pend[0] ? 2'd1 : r_pend[1] ? 2'd2 : 2'd3;
  assign w_sel_done = (r_sel == 2'd1 && arp_tx_done) || (r_sel == 2'd2 && icmp_tx_done) ||
                      (r_sel == 2'd3 && udp_tx_done);
  assign w_src_en   = r_sel == 2'd1 ? arp_gmii_tx_en : r_sel == 2'd2 ? icmp_gmii_tx_en :
                      r_sel == 2'd3 ? udp_gmii_tx_en : 1'b0;
  assign w_src_txd  = r_sel == 2'd1 ? arp_gmii_txd : r_sel == 2'd2 ? icmp_gmii_txd :
                      r_sel == 2'd3 ? udp_gmii_txd : 8'h00;
  assign w_fwd      = r_state == S_LAUNCH || r_state == S_ACTIVE;
  // A flag is consumed while its source is in LAUNCH; a start in that same cycle re-arms it.
  assign w_clr      = r_state == S_LAUNCH ? {r_sel == 2'd3, r_sel == 2'd2, r_sel == 2'd1} : 3'b000;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_sel  = r_sel;
    w_go   = 3'b000;
    w_tmo  = 1'b0;
    case (r_state)
      S_IDLE: if (|r_pend) begin
        w_next = S_LAUNCH;
        w_sel  = w_pick;
        w_go   = {w_pick == 2'd3, w_pick == 2'd2, w_pick == 2'd1};
      end
      S_LAUNCH: w_next = S_ACTIVE;
      // Done takes precedence over a watchdog expiry in the same cycle.
      S_ACTIVE: if (w_sel_done) w_next = S_GAP;
        else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_next = S_GAP;
          w_tmo  = 1'b1;
        end
      S_GAP: if (r_gap == GAP_W'(IFG_CYCLES - 1)) begin
        w_next = S_IDLE;
        w_sel  = 2'd0;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_sel   <= '0;
      r_wd    <= '0;
      r_gap   <= '0;
      r_go    <= '0;
      r_tmo   <= 1'b0;
      r_busy  <= 1'b0;
      r_tx_en <= 1'b0;
      r_txd   <= '0;
    end else begin
      r_pend  <= w_start | (r_pend & ~w_clr);
      r_sel   <= w_sel;
      r_wd    <= r_state == S_ACTIVE ? r_wd + 1'b1 : '0;
      r_gap   <= r_state == S_GAP ? r_gap + 1'b1 : '0;
      r_go    <= w_go;
      r_tmo   <= w_tmo;
      r_busy  <= w_next != S_IDLE;
      r_tx_en <= w_fwd && w_src_en;
      r_txd   <= w_fwd ? w_src_txd : 8'h00;
    end
  end
  assign arp_tx_go   = r_go[0];
  assign icmp_tx_go  = r_go[1];
  assign udp_tx_go   = r_go[2];
  assign gmii_tx_en  = r_tx_en;
  assign gmii_txd    = r_txd;
  assign sel         = r_sel;
  assign busy        = r_busy;
  assign timeout_err = r_tmo;
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed scoreboard bench for eth_tx_sched (IFG_CYCLES=12, TIMEOUT=16).
module tb_eth_tx_sched;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       arp_tx_start = 1'b0, icmp_tx_start = 1'b0, udp_tx_start = 1'b0;
  logic       arp_tx_done, icmp_tx_done, udp_tx_done;
  logic       arp_gmii_tx_en, icmp_gmii_tx_en, udp_gmii_tx_en;
  logic [7:0] arp_gmii_txd, icmp_gmii_txd, udp_gmii_txd;
  logic       arp_tx_go, icmp_tx_go, udp_tx_go, gmii_tx_en, busy, timeout_err;
  logic [7:0] gmii_txd;
  logic [1:0] sel;
  logic [2:0] go_vec;
  int         checks = 0, failures = 0, tmo_exp = 0, mon_s;
  int         q_go[$];
  logic [7:0] q_byte[$];
  assign go_vec = {udp_tx_go, icmp_tx_go, arp_tx_go};
  always #5 clk = ~clk;
  eth_tx_sched #(.IFG_CYCLES(12), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .arp_tx_start(arp_tx_start), .icmp_tx_start(icmp_tx_start), .udp_tx_start(udp_tx_start),
    .arp_tx_done(arp_tx_done), .icmp_tx_done(icmp_tx_done), .udp_tx_done(udp_tx_done),
    .arp_gmii_tx_en(arp_gmii_tx_en), .arp_gmii_txd(arp_gmii_txd),
    .icmp_gmii_tx_en(icmp_gmii_tx_en), .icmp_gmii_txd(icmp_gmii_txd),
    .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd),
    .arp_tx_go(arp_tx_go), .icmp_tx_go(icmp_tx_go), .udp_tx_go(udp_tx_go),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .sel(sel), .busy(busy), .timeout_err(timeout_err)
  );
  task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(int s, logic en, logic [7:0] d, logic dn);
    arp_gmii_tx_en  = en && s == 1;
    icmp_gmii_tx_en = en && s == 2;
    udp_gmii_tx_en  = en && s == 3;
    arp_gmii_txd    = s == 1 ? d : 8'h00;
    icmp_gmii_txd   = s == 2 ? d : 8'h00;
    udp_gmii_txd    = s == 3 ? d : 8'h00;
    arp_tx_done     = dn && s == 1;
    icmp_tx_done    = dn && s == 2;
    udp_tx_done     = dn && s == 3;
  endtask
  task automatic expect_go(int s);
    step();
    chk("go_launch", {29'b0, go_vec}, 32'(3'b001 << (s - 1)));
    chk("launch_sel", {30'b0, sel}, s);
    chk("launch_busy", {31'b0, busy}, 1);
  endtask
  // Called in the LAUNCH cycle; ends in the IDLE cycle after the 12-cycle gap.
  // inj 1: ICMP start + stray ARP done at byte 1; inj 2: UDP starts at bytes 0, 2, 4.
  task automatic frame(int s, int nb, int inj);
    logic [7:0] d;
    step();
    chk("go_width", {29'b0, go_vec}, 0);
    for (int i = 0; i < nb; i++) begin
      d = 8'($urandom);
      drive(s, 1'b1, d, 1'b0);
      q_byte.push_back(d);
      icmp_tx_start = inj == 1 && i == 1;
      if (inj == 1) arp_tx_done = i == 1;
      udp_tx_start = inj == 2 && i % 2 == 0 && i < 6;
      if (inj == 1 && i == 1) q_go.push_back(2);
      if (inj == 2 && i == 0) q_go.push_back(3);
      step();
      chk("byte_latency", {24'b0, gmii_txd}, {24'b0, d});
      chk("byte_en", {31'b0, gmii_tx_en}, 1);
      chk("frame_sel", {30'b0, sel}, s);
    end
    icmp_tx_start = 1'b0;
    udp_tx_start  = 1'b0;
    drive(s, 1'b0, 8'h00, 1'b1);
    step();
    drive(s, 1'b1, 8'hEE, 1'b0);
    for (int g = 0; g < 12; g++) begin
      chk("gap_en", {31'b0, gmii_tx_en}, 0);
      chk("gap_busy", {31'b0, busy}, 1);
      chk("gap_no_tmo", {31'b0, timeout_err}, 0);
      step();
      drive(s, 1'b0, 8'h00, 1'b0);
    end
    chk("idle_sel", {30'b0, sel}, 0);
    chk("idle_busy", {31'b0, busy}, 0);
  endtask
  always @(negedge clk) begin
    if (go_vec != 3'b000) begin
      if (q_go.size() == 0) chk("go_unexpected", {29'b0, go_vec}, 0);
      else begin
        mon_s = q_go.pop_front();
        chk("go_order", {29'b0, go_vec}, 32'(3'b001 << (mon_s - 1)));
        chk("go_sel", {30'b0, sel}, mon_s);
      end
    end
    if (gmii_tx_en) begin
      if (q_byte.size() == 0) chk("byte_unexpected", {24'b0, gmii_txd}, 32'h100);
      else chk("byte_order", {24'b0, gmii_txd}, {24'b0, q_byte.pop_front()});
    end
    if (timeout_err) begin
      if (tmo_exp == 0) chk("tmo_unexpected", {31'b0, timeout_err}, 0);
      else tmo_exp--;
    end
  end
  initial begin
    drive(0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", {31'b0, gmii_tx_en}, 0);
    chk("rst_txd", {24'b0, gmii_txd}, 0);
    chk("rst_sel", {30'b0, sel}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_go", {29'b0, go_vec}, 0);
    chk("rst_tmo", {31'b0, timeout_err}, 0);
    rst_n = 1'b1;
    step();
    // single UDP frame
    udp_tx_start = 1'b1;
    q_go.push_back(3);
    step();
    udp_tx_start = 1'b0;
    chk("go_early", {29'b0, go_vec}, 0);
    expect_go(3);
    frame(3, 4, 0);
    // simultaneous starts served ARP, ICMP, UDP
    arp_tx_start = 1'b1;
    icmp_tx_start = 1'b1;
    udp_tx_start = 1'b1;
    q_go.push_back(1);
    q_go.push_back(2);
    q_go.push_back(3);
    step();
    arp_tx_start = 1'b0;
    icmp_tx_start = 1'b0;
    udp_tx_start = 1'b0;
    expect_go(1);
    frame(1, 3, 0);
    expect_go(2);
    frame(2, 2, 0);
    expect_go(3);
    frame(3, 2, 0);
    // ICMP start and stray ARP done while UDP owns the port
    udp_tx_start = 1'b1;
    q_go.push_back(3);
    step();
    udp_tx_start = 1'b0;
    expect_go(3);
    frame(3, 4, 1);
    expect_go(2);
    frame(2, 2, 0);
    // watchdog release with UDP pending
    icmp_tx_start = 1'b1;
    q_go.push_back(2);
    step();
    icmp_tx_start = 1'b0;
    expect_go(2);
    step();
    chk("wd_go_width", {29'b0, go_vec}, 0);
    udp_tx_start = 1'b1;
    q_go.push_back(3);
    for (int k = 1; k <= 16; k++) begin
      chk("wd_no_tmo", {31'b0, timeout_err}, 0);
      chk("wd_busy", {31'b0, busy}, 1);
      if (k == 16) tmo_exp = 1;
      step();
      udp_tx_start = 1'b0;
    end
    chk("tmo_pulse", {31'b0, timeout_err}, 1);
    chk("tmo_gap_en", {31'b0, gmii_tx_en}, 0);
    step();
    chk("tmo_width", {31'b0, timeout_err}, 0);
    repeat (10) step();
    chk("tmo_gap_last_busy", {31'b0, busy}, 1);
    step();
    chk("tmo_idle_busy", {31'b0, busy}, 0);
    chk("tmo_idle_sel", {30'b0, sel}, 0);
    expect_go(3);
    frame(3, 2, 0);
    // repeated UDP starts merge; done lands on the last watchdog cycle
    udp_tx_start = 1'b1;
    q_go.push_back(3);
    step();
    udp_tx_start = 1'b0;
    expect_go(3);
    frame(3, 15, 2);
    expect_go(3);
    frame(3, 2, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("merge_no_extra_go", {29'b0, go_vec}, 0);
    end
    // reset mid-frame with ICMP pending
    udp_tx_start = 1'b1;
    q_go.push_back(3);
    step();
    udp_tx_start = 1'b0;
    expect_go(3);
    step();
    drive(3, 1'b1, 8'h5A, 1'b0);
    icmp_tx_start = 1'b1;
    step();
    icmp_tx_start = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    chk("pre_rst_txd", {24'b0, gmii_txd}, 32'h5A);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {31'b0, gmii_tx_en}, 0);
    chk("mid_rst_txd", {24'b0, gmii_txd}, 0);
    chk("mid_rst_sel", {30'b0, sel}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_go", {29'b0, go_vec}, 0);
      chk("post_rst_busy", {31'b0, busy}, 0);
    end
    icmp_tx_start = 1'b1;
    q_go.push_back(2);
    step();
    icmp_tx_start = 1'b0;
    expect_go(2);
    frame(2, 3, 0);
    repeat (3) step();
    chk("go_queue_drained", q_go.size(), 0);
    chk("byte_queue_drained", q_byte.size(), 0);
    chk("tmo_drained", tmo_exp, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
